mul_operand_feeder: RTL and testbench
=====================================

Name: mul_operand_feeder

Overview:
- Upstream stage of the sequential multiplier (data_path + controlpath pair).
- Accepts operand pairs on a valid/ready input and queues them in a small FIFO.
- Issues pairs one at a time to the multiplier via mul_a/mul_b/mul_start and waits for mul_done.
- Captures mul_product and presents it on a valid/ready output.

Parameters:
- WIDTH, 2: operand width in bits; product width is 2*WIDTH.
- DEPTH, 4: operand FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_start  out  1  one-cycle start pulse to the multiplier control path.
- mul_done  in  1  multiplier finished; mul_product valid this cycle.
- mul_product  in  2*WIDTH  multiplier result.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_product  out  2*WIDTH  captured product.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high): FIFO empty, FSM IDLE, all outputs 0; in_ready is 1 once rst deasserts.
- FIFO rules:
  - Push on in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH); no pass-through when full.
  - A push and a pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if fifo_count != 0, pop the head into the mul_a/mul_b registers and go to ISSUE. If empty, stay.
  - ISSUE: mul_start = 1 for exactly this cycle; go to WAIT.
  - WAIT: mul_start = 0; mul_a/mul_b held stable. On mul_done, register mul_product into out_product, set out_valid, go to HOLD.
  - HOLD: out_valid = 1 and out_product stable. On out_ready, clear out_valid and go to IDLE.
- Latency:
  - Push into an empty idle block gives mul_start 2 cycles later (push edge, then IDLE pop edge).
  - mul_done gives out_valid the next cycle.
  - Minimum 1 idle cycle between successive mul_start pulses.
- mul_done in IDLE, ISSUE or HOLD is ignored; no capture and no state change.
- Zero operands (A=0 or B=0) are issued normally; the result comes from the multiplier.
- mul_a/mul_b retain the last issued pair until the next pop.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-operation: the in-flight pair and all queued pairs are discarded, and mul_start drops immediately. The multiplier is reset from the same rst.
- Capacity: with out_ready held low, the block accepts DEPTH+1 pairs (one in flight, DEPTH queued) before in_ready falls.

Optional Feature:
- Macro: MUL_FEED_TIMEOUT_EN.
- Defined:
  - Adds output timeout (1 bit) and a WAIT-state cycle counter.
  - If mul_done is not seen within 2**WIDTH+4 cycles of entering WAIT: out_product = 0, out_valid = 1, timeout = 1, go to HOLD.
  - timeout clears when the result is accepted.
  - The counter resets on entering WAIT.
- Undefined: no timeout port and no counter; WAIT waits indefinitely.

Decomposition:
- Package mul_feed_pkg:
  - feed_state_t enum {IDLE, ISSUE, WAIT, HOLD}.
  - Default WIDTH and DEPTH constants.
  - Timeout limit function of WIDTH.
- Sub-module mul_feed_fifo:
  - Parameterised WIDTH and DEPTH; entry width 2*WIDTH.
  - push/pop/full/empty/count.
- Top instantiates mul_feed_fifo plus the FSM and the output register.

Test Plan:
- Single pair: push A=2, B=2. Expect mul_start pulse 2 cycles later, mul_a=2, mul_b=2. Model done after 4 cycles with product 4: out_valid next cycle, out_product=4; out_ready=1 returns to IDLE with busy=0.
- Back-to-back: push (3,3), (1,2), (0,3) on consecutive cycles, out_ready=1. Expect outputs 9, 2, 0 in order, exactly one mul_start per pair, no drops.
- Backpressure: out_ready=0, push 6 pairs. Expect in_ready low after the 5th accept, fifo_count=4, the 6th held. Release out_ready: all 5 results in order.
- Spurious done: assert mul_done in IDLE and in HOLD. Expect no capture, no state change, out_product unchanged.
- Reset mid-WAIT: 3 pairs queued, rst asserted during WAIT. Expect immediate fifo_count=0, out_valid=0, mul_start=0, in_ready=1 after release.
- MUL_FEED_TIMEOUT_EN build: push (2,3), never assert mul_done. Expect out_valid and timeout=1 exactly 2**WIDTH+4 cycles after entering WAIT, out_product=0.

Source files
------------

// File: rtl/mul_feed_pkg.sv
// Shared types and constants for the multiplier operand feeder.
// - feed_state_t  : feeder FSM states
// - DEFAULT_WIDTH : default operand width
// - DEFAULT_DEPTH : default operand FIFO depth
// - timeout_limit : WAIT-state cycle limit used when MUL_FEED_TIMEOUT_EN is defined
package mul_feed_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} feed_state_t;

  localparam int unsigned DEFAULT_WIDTH = 2;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Worst-case multiplier latency plus margin.
  function automatic int unsigned timeout_limit(input int unsigned width);
    return (32'd1 << width) + 32'd4;
  endfunction

endpackage

// File: rtl/mul_feed_fifo.sv
// Operand-pair FIFO for the multiplier feeder. Each entry is {a, b}.
// Ports:
//   clk, rst            clock, async active-high reset
//   push, push_data     write request (ignored when full), entry data
//   pop, pop_data       read request (ignored when empty), head entry (combinational)
//   full, empty, count  occupancy status
module mul_feed_fifo
  import mul_feed_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [2*WIDTH-1:0]         push_data,
  input  logic                       pop,
  output logic [2*WIDTH-1:0]         pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mul_operand_feeder.sv
// Upstream feeder for the sequential multiplier. Queues operand pairs, issues them one at
// a time (mul_a/mul_b + one-cycle mul_start), waits for mul_done and holds the product on
// a valid/ready output.
// Optional build macro: MUL_FEED_TIMEOUT_EN adds a WAIT-state watchdog and the timeout port.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready/in_a/in_b    operand pair input
//   mul_a/mul_b/mul_start          issue interface to the multiplier
//   mul_done/mul_product           completion from the multiplier
//   out_valid/out_ready/out_product  result output
//   busy, fifo_count               status
//   timeout                        (MUL_FEED_TIMEOUT_EN only) result is a timeout, product 0
module mul_operand_feeder
  import mul_feed_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_start,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic                   busy,
`ifdef MUL_FEED_TIMEOUT_EN
  output logic                   timeout,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  feed_state_t        state_q, state_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0] out_product_q;
  logic               capture;

  // Held low during reset so nothing is accepted until rst deasserts.
  assign in_ready  = !fifo_full && !rst;
  assign fifo_push = in_valid && in_ready;

  mul_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef MUL_FEED_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = timeout_limit(WIDTH);
  localparam int unsigned TO_CW    = $clog2(TO_LIMIT);

  logic [TO_CW-1:0] wait_cnt_q;
  logic             timeout_q;
  logic             timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // Cleared in ISSUE so the count starts at 0 on the first WAIT cycle.
      if (state_q == ISSUE)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timed_out)                        timeout_q <= 1'b1;
      else if (state_q == HOLD && out_ready) timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; mul_done outside WAIT is deliberately ignored.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
`ifdef MUL_FEED_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          state_d = HOLD;
          capture = 1'b1;
        end
`ifdef MUL_FEED_TIMEOUT_EN
        else if (wait_cnt_q == TO_CW'(TO_LIMIT - 1)) begin
          state_d   = HOLD;
          timed_out = 1'b1;
        end
`endif
      end
      HOLD:  if (out_ready) state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fifo_pop  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:  fifo_pop  = !fifo_empty;
      ISSUE: mul_start = 1'b1;
      WAIT:  ;
      HOLD:  out_valid = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE) || !fifo_empty;

  // Operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_product_q <= '0;
    end else begin
      if (fifo_pop) {mul_a_q, mul_b_q} <= fifo_head;
      if (capture)  out_product_q <= mul_product;
`ifdef MUL_FEED_TIMEOUT_EN
      else if (timed_out) out_product_q <= '0;
`endif
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_product = out_product_q;

endmodule

// File: tb/tb_mul_operand_feeder.sv
module tb_mul_operand_feeder;
  import mul_feed_pkg::*;

  localparam int unsigned W      = 2;
  localparam int unsigned D      = 4;
  localparam int unsigned TO_LIM = 8;  // 2**W + 4

`ifdef MUL_FEED_TIMEOUT_EN
  localparam int unsigned PARK = 4;    // stay below the watchdog
`else
  localparam int unsigned PARK = 12;   // longer than any timeout: WAIT must persist
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_a = '0, in_b = '0;
  logic [W-1:0]        mul_a, mul_b;
  logic                mul_start;
  logic                mul_done;
  logic [2*W-1:0]      mul_product;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [2*W-1:0]      out_product;
  logic                busy;
  logic [$clog2(D):0]  fifo_count;
`ifdef MUL_FEED_TIMEOUT_EN
  logic                timeout;
`endif

  // Multiplier stand-in plus a spurious-done injector.
  logic                model_done = 1'b0;
  logic [2*W-1:0]      model_prod = '0;
  logic                spur_done = 1'b0;
  logic                mul_en = 1'b0;
  assign mul_done    = model_done | spur_done;
  assign mul_product = spur_done ? 4'hF : model_prod;

  int n_cmp = 0, n_fail = 0;
  int start_cnt = 0, dbl_start = 0;
  logic prev_start = 1'b0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  mul_operand_feeder #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy),
`ifdef MUL_FEED_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .fifo_count  (fifo_count)
  );

  // Multiplier model: done 4 cycles after the start pulse is seen.
  initial begin : mul_model
    logic [W-1:0] a, b;
    forever begin
      @(negedge clk);
      if (mul_en && mul_start) begin
        a = mul_a;
        b = mul_b;
        repeat (3) @(negedge clk);
        model_prod = (2*W)'(a) * (2*W)'(b);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  initial begin : start_mon
    forever begin
      @(negedge clk);
      if (mul_start) begin
        start_cnt++;
        if (prev_start) dbl_start++;
      end
      prev_start = mul_start;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_ready: got in_ready 0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got out_valid 0, expected 1", name);
    end
  endtask

  task automatic collect(input int first, input int n);
    int c;
    for (int i = first; i < first + n; i++) begin
      wait_valid("collect_valid", c);
      check($sformatf("result[%0d]", i), out_product, tbl[i].prod);
      @(negedge clk);
    end
  endtask

  initial begin : main
    int c, s0;
    tbl[0]  = '{2'd3, 2'd3, 4'd9};
    tbl[1]  = '{2'd1, 2'd2, 4'd2};
    tbl[2]  = '{2'd0, 2'd3, 4'd0};
    tbl[3]  = '{2'd2, 2'd2, 4'd4};
    tbl[4]  = '{2'd3, 2'd2, 4'd6};
    tbl[5]  = '{2'd3, 2'd0, 4'd0};
    tbl[6]  = '{2'd1, 2'd1, 4'd1};
    tbl[7]  = '{2'd2, 2'd3, 4'd6};
    tbl[8]  = '{2'd3, 2'd1, 4'd3};
    tbl[9]  = '{2'd2, 2'd1, 4'd2};
    tbl[10] = '{2'd3, 2'd3, 4'd9};
    tbl[11] = '{2'd1, 2'd2, 4'd2};

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_product", out_product, 0);
    check("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single pair with exact latency
    mul_en = 1'b1;
    push(2'd2, 2'd2);
    check("single_count", fifo_count, 1);
    check("single_start_early", mul_start, 0);
    check("single_busy", busy, 1);
    @(negedge clk);
    check("single_start", mul_start, 1);
    check("single_mul_a", mul_a, 2);
    check("single_mul_b", mul_b, 2);
    check("single_popped", fifo_count, 0);
    @(negedge clk);
    check("single_start_pulse", mul_start, 0);
    wait_valid("single_valid", c);
    check("single_latency", c, 3);
    check("single_product", out_product, 4);
    repeat (2) @(negedge clk);
    check("single_hold_valid", out_valid, 1);
    check("single_hold_product", out_product, 4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_accept_valid", out_valid, 0);
    check("single_idle_busy", busy, 0);

    // Spurious done in IDLE
    mul_en = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_idle_valid", out_valid, 0);
    check("spur_idle_product", out_product, 4);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_start", mul_start, 0);

    // Spurious done in HOLD
    mul_en = 1'b1;
    push(2'd1, 2'd3);
    wait_valid("spur_hold_valid0", c);
    check("spur_hold_first", out_product, 3);
    @(negedge clk);
    mul_en = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_hold_product", out_product, 3);
    check("spur_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back table vectors
    mul_en = 1'b1;
    s0 = start_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) push(tbl[i].a, tbl[i].b);
      end
      collect(0, 6);
    join
    check("b2b_starts", start_cnt - s0, 6);

    // Backpressure: DEPTH+1 accepted, then in_ready falls
    out_ready = 1'b0;
    s0 = start_cnt;
    for (int i = 6; i < 11; i++) push(tbl[i].a, tbl[i].b);
    check("bp_in_ready", in_ready, 0);
    check("bp_count", fifo_count, 4);
    in_a = tbl[11].a;
    in_b = tbl[11].b;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_count_held", fifo_count, 4);
    check("bp_in_ready_held", in_ready, 0);
    check("bp_first_valid", out_valid, 1);
    out_ready = 1'b1;
    fork
      push(tbl[11].a, tbl[11].b);
      collect(6, 6);
    join
    check("bp_starts", start_cnt - s0, 6);

    // Reset while parked in WAIT with 3 pairs queued
    mul_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(tbl[i].a, tbl[i].b);
    repeat (PARK) @(negedge clk);
    check("rstw_count", fifo_count, 3);
    check("rstw_busy", busy, 1);
    check("rstw_valid_before", out_valid, 0);
    rst = 1'b1;
    #1;
    check("rstw_count0", fifo_count, 0);
    check("rstw_valid", out_valid, 0);
    check("rstw_start", mul_start, 0);
    check("rstw_busy0", busy, 0);
    check("rstw_mul_a", mul_a, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_in_ready", in_ready, 1);
    @(negedge clk);
    check("rstw_still_idle", busy, 0);
    mul_en = 1'b1;
    out_ready = 1'b1;
    push(2'd3, 2'd2);
    wait_valid("rstw_fresh_valid", c);
    check("rstw_fresh_product", out_product, 6);
    @(negedge clk);

`ifdef MUL_FEED_TIMEOUT_EN
    // Watchdog fires when mul_done never arrives
    mul_en = 1'b0;
    out_ready = 1'b0;
    push(2'd2, 2'd3);
    c = 0;
    while (!mul_start && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("to_start_seen", mul_start, 1);
    @(negedge clk);
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("to_latency", c, TO_LIM);
    check("to_flag", timeout, 1);
    check("to_product", out_product, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("to_flag_clear", timeout, 0);
    check("to_valid_clear", out_valid, 0);
`endif

    check("start_single_cycle", dbl_start, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
